fsmc_reg_bank: RTL and testbench

Register bank and stream buffer directly downstream of `fsmc_interface`. It consumes the decoded chip-select index, write-phase flag and MCU write data, and commits each completed MCU write into control, scratch or TX-FIFO registers. It returns read data (status, RX-FIFO head, scratch) to `fsmc_interface` for MCU reads. Two synchronous FIFOs bridge MCU-side accesses and on-chip user logic through valid/ready streams.

---
 rtl/fsmc_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/fsmc_reg_bank.sv | 151 +++++++++++++++
 tb/tb_fsmc_reg_bank.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// rtl/fsmc_pkg.sv - shared register map and bit positions for the FSMC register bank
package fsmc_pkg;

  localparam int DW = 16;

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_TX_DATA  = 4'd2;
  localparam logic [3:0] REG_RX_DATA  = 4'd3;
  localparam logic [3:0] REG_RX_POP   = 4'd4;
  localparam logic [3:0] REG_ERR      = 4'd5;
  localparam logic [3:0] REG_SCRATCH0 = 4'd6;
  localparam logic [3:0] REG_SCRATCH1 = 4'd7;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_TX_FLUSH = 1;
  localparam int CTRL_RX_FLUSH = 2;

  localparam int ST_RX_FULL    = 15;
  localparam int ST_RX_EMPTY   = 14;
  localparam int ST_TX_FULL    = 13;
  localparam int ST_TX_EMPTY   = 12;
  localparam int ST_RX_CNT_LSB = 5;
  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_CNT_W      = 5;

  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UNF = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through synchronous FIFO with flush
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [DW-1:0]              rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Occupancy follows the net effect of this cycle's push and pop
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers, occupancy and storage; flush discards everything, including this cycle's traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fsmc_reg_bank.sv
// rtl/fsmc_reg_bank.sv - MCU register bank with TX/RX stream FIFOs behind fsmc_interface
module fsmc_reg_bank
  import fsmc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cs,
  input  logic          state,
  input  logic [DW-1:0] bus_data,
  output logic [DW-1:0] bus_rdata,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [DW-1:0] ctrl,
  output logic          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          state_q;
  logic          irq_en_q;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] scratch0_q, scratch1_q;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          commit;
  logic          wr_ctrl, wr_tx, wr_rx_pop, wr_err;
  logic          tx_flush, rx_flush;
  logic          tx_pop, rx_push;
  logic          tx_ovf_set, rx_unf_set;
  logic [DW-1:0] rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [DW-1:0] status;

  // An MCU write completes on the falling edge of the write-phase flag
  assign commit    = state_q & ~state;
  assign wr_ctrl   = commit && (cs == REG_CTRL);
  assign wr_tx     = commit && (cs == REG_TX_DATA);
  assign wr_rx_pop = commit && (cs == REG_RX_POP);
  assign wr_err    = commit && (cs == REG_ERR);

  // Flush bits act for one cycle only and are never stored
  assign tx_flush = wr_ctrl & bus_data[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl & bus_data[CTRL_RX_FLUSH];

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;
  assign rx_unf_set = wr_rx_pop & rx_empty;

  assign ctrl      = {{(DW-1){1'b0}}, irq_en_q};
  assign irq       = irq_en_q & ~rx_empty;
  assign bus_rdata = rdata_q;

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .wdata (bus_data),
    .pop   (tx_pop),
    .flush (tx_flush),
    .rdata (tx_data),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (wr_rx_pop),
    .flush (rx_flush),
    .rdata (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Sticky error flags: hardware sets, MCU clears by writing ones; a set wins over a clear
  always_comb begin
    err_d = err_q;
    if (wr_err) begin
      err_d = err_q & ~bus_data[1:0];
    end
    if (tx_ovf_set) begin
      err_d[ERR_TX_OVF] = 1'b1;
    end
    if (rx_unf_set) begin
      err_d[ERR_RX_UNF] = 1'b1;
    end
  end

  // STATUS snapshot and read mux; write-only and unmapped indices read as zero
  always_comb begin
    status                                  = '0;
    status[ST_RX_FULL]                      = rx_full;
    status[ST_RX_EMPTY]                     = rx_empty;
    status[ST_TX_FULL]                      = tx_full;
    status[ST_TX_EMPTY]                     = tx_empty;
    status[ST_RX_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(rx_count);
    status[ST_TX_CNT_LSB +: ST_CNT_W]       = ST_CNT_W'(tx_count);
    rdata_d = '0;
    case (cs)
      REG_CTRL:     rdata_d = ctrl;
      REG_STATUS:   rdata_d = status;
      REG_RX_DATA:  rdata_d = rx_empty ? '0 : rx_head;
      REG_ERR:      rdata_d = {{(DW-2){1'b0}}, err_q};
      REG_SCRATCH0: rdata_d = scratch0_q;
      REG_SCRATCH1: rdata_d = scratch1_q;
      default:      rdata_d = '0;
    endcase
  end

  // Commit detection, register writes and the registered read path
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      err_q      <= '0;
      scratch0_q <= '0;
      scratch1_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (wr_ctrl) begin
        irq_en_q <= bus_data[CTRL_IRQ_EN];
      end
      if (commit && (cs == REG_SCRATCH0)) begin
        scratch0_q <= bus_data;
      end
      if (commit && (cs == REG_SCRATCH1)) begin
        scratch1_q <= bus_data;
      end
    end
  end

endmodule

// File: tb/tb_fsmc_reg_bank.sv
// tb/tb_fsmc_reg_bank.sv - self-checking bench for fsmc_reg_bank against a queue-based model
module tb_fsmc_reg_bank;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cs;
  logic        state;
  logic [15:0] bus_data;
  logic [15:0] bus_rdata;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] ctrl;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  bit          ctrl_en;
  bit   [1:0]  err;
  logic [15:0] scr0, scr1;
  bit          rnd_mode = 1'b0;

  fsmc_reg_bank #(.DEPTH(DEPTH), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .state     (state),
    .bus_data  (bus_data),
    .bus_rdata (bus_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ctrl      (ctrl),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] idx);
    logic [15:0] s;
    s = '0;
    case (idx)
      4'd0: s = {15'd0, ctrl_en};
      4'd1: begin
        s[15]  = (rxq.size() == DEPTH);
        s[14]  = (rxq.size() == 0);
        s[13]  = (txq.size() == DEPTH);
        s[12]  = (txq.size() == 0);
        s[9:5] = 5'(rxq.size());
        s[4:0] = 5'(txq.size());
      end
      4'd3: s = (rxq.size() > 0) ? rxq[0] : 16'h0000;
      4'd5: s = {14'd0, err};
      4'd6: s = scr0;
      4'd7: s = scr1;
      default: s = '0;
    endcase
    return s;
  endfunction

  task automatic model_reset();
    txq.delete();
    rxq.delete();
    ctrl_en = 1'b0;
    err     = 2'b00;
    scr0    = '0;
    scr1    = '0;
  endtask

  // One clock: predict the effect of the current inputs, advance, then compare stream outputs
  task automatic tick(input bit commit);
    bit          tpop, rpush, tpush, rpop, tfl, rfl;
    logic [15:0] rxd, bd;
    if (rnd_mode) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data  = 16'($urandom);
    end
    tpop  = tx_ready && (txq.size() > 0);
    rpush = rx_valid && (rxq.size() < DEPTH);
    tpush = 0; rpop = 0; tfl = 0; rfl = 0;
    rxd = rx_data;
    bd  = bus_data;
    if (commit) begin
      case (cs)
        4'd0: begin ctrl_en = bd[0]; tfl = bd[1]; rfl = bd[2]; end
        4'd2: if (txq.size() == DEPTH && !tpop) err[0] = 1'b1; else tpush = 1;
        4'd4: if (rxq.size() == 0) err[1] = 1'b1; else rpop = 1;
        4'd5: err = err & ~bd[1:0];
        4'd6: scr0 = bd;
        4'd7: scr1 = bd;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    if (tfl) txq.delete();
    else begin
      if (tpop) void'(txq.pop_front());
      if (tpush) txq.push_back(bd);
    end
    if (rfl) rxq.delete();
    else begin
      if (rpop) void'(rxq.pop_front());
      if (rpush) rxq.push_back(rxd);
    end
    chk("tx_valid", 16'(tx_valid), 16'(txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_ready", 16'(rx_ready), 16'(rxq.size() < DEPTH));
    chk("irq", 16'(irq), 16'(ctrl_en && rxq.size() > 0));
    chk("ctrl", ctrl, {15'd0, ctrl_en});
  endtask

  task automatic wr(input logic [3:0] idx, input logic [15:0] d, input bit rdy = 1'b0);
    cs       = idx;
    bus_data = d;
    state    = 1'b1;
    tick(1'b0);
    state = 1'b0;
    if (rdy) tx_ready = 1'b1;
    tick(1'b1);
    if (rdy) tx_ready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] idx, input logic [15:0] exp);
    cs = idx;
    tick(1'b0);
    chk(tag, bus_rdata, exp);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    state    = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    cs = 4'd0; bus_data = '0; rx_data = '0;
    do_reset();

    // reset state
    chk("rst_bus_rdata", bus_rdata, 16'h0000);
    chk("rst_ctrl", ctrl, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
    chk("rst_tx_data", tx_data, 16'h0000);
    chk("rst_rx_ready", 16'(rx_ready), 16'h0001);
    rd("rst_status", 4'd1, 16'h5000);
    rd("rst_err", 4'd5, 16'h0000);
    rd("rst_scratch1", 4'd7, 16'h0000);

    // TX push and drain
    wr(4'd2, 16'h0F0F);
    wr(4'd2, 16'h1234);
    chk("tx_head", tx_data, 16'h0F0F);
    rd("tx_status2", 4'd1, 16'h4002);
    rd("tx_data_reads0", 4'd2, 16'h0000);
    tx_ready = 1'b1;
    tick(1'b0);
    chk("tx_second", tx_data, 16'h1234);
    tick(1'b0);
    tx_ready = 1'b0;
    chk("tx_drained", 16'(tx_valid), 16'h0000);

    // TX overflow and W1C
    for (int i = 0; i < 17; i++) wr(4'd2, 16'(16'hA000 + i));
    rd("ovf_status", 4'd1, 16'h6010);
    rd("ovf_err", 4'd5, 16'h0001);
    wr(4'd5, 16'h0001);
    rd("ovf_err_clr", 4'd5, 16'h0000);

    // full TX with push and pop on the commit cycle
    wr(4'd2, 16'hBEEF, 1'b1);
    rd("full_pp_status", 4'd1, 16'h6010);
    rd("full_pp_err", 4'd5, 16'h0000);

    // RX path
    rx_data = 16'h2321; rx_valid = 1'b1;
    tick(1'b0);
    rx_valid = 1'b0;
    wr(4'd0, 16'h0001);
    chk("rx_irq_on", 16'(irq), 16'h0001);
    rd("rx_head", 4'd3, 16'h2321);
    wr(4'd4, 16'h0000);
    chk("rx_irq_off", 16'(irq), 16'h0000);
    rd("rx_empty_status", 4'd1, 16'h6010);
    rd("rx_empty_read", 4'd3, 16'h0000);
    wr(4'd4, 16'h0000);
    rd("rx_unf_err", 4'd5, 16'h0002);
    wr(4'd5, 16'h0002);

    // RX fill to full
    rx_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      rx_data = 16'(16'h7700 + i);
      tick(1'b0);
    end
    rx_valid = 1'b0;
    chk("rx_full_ready", 16'(rx_ready), 16'h0000);
    rd("rx_full_status", 4'd1, 16'hA210);

    // flush both FIFOs during a TX handshake
    wr(4'd0, 16'h0006, 1'b1);
    rd("flush_status", 4'd1, 16'h5000);
    rd("flush_ctrl", 4'd0, 16'h0000);

    // scratch round trip
    wr(4'd6, 16'hC0DE);
    wr(4'd7, 16'h5A5A);
    rd("scratch0", 4'd6, 16'hC0DE);
    rd("scratch1", 4'd7, 16'h5A5A);
    wr(4'd9, 16'hFFFF);
    rd("unmapped", 4'd9, 16'h0000);

    // randomized traffic against the model
    rnd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [3:0]  idx;
      logic [15:0] d;
      op = int'($urandom_range(0, 9));
      if (op < 6) begin
        idx = (op < 3) ? 4'd2 : ((op == 3) ? 4'd4 : 4'($urandom_range(0, 15)));
        d   = 16'($urandom);
        if (idx == 4'd0 && $urandom_range(0, 3) != 0) d[2:1] = 2'b00;
        wr(idx, d);
      end else if (op < 9) begin
        idx = 4'($urandom_range(0, 15));
        cs  = idx;
        rd("rnd_read", idx, model_read(idx));
      end else begin
        tick(1'b0);
      end
    end
    rnd_mode = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;

    // reset in the middle of a write
    do_reset();
    cs = 4'd6; bus_data = 16'hABCD; state = 1'b1;
    tick(1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    state = 1'b0;
    tick(1'b0);
    tick(1'b0);
    rd("midwrite_scratch0", 4'd6, 16'h0000);
    rd("midwrite_status", 4'd1, 16'h5000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
